// File: rtl/mem_access_unit.sv
// MEM stage with MEM/WB register: word load/store on a local RAM with a fixed
// number of wait states, upstream stall generation and branch-select output.
module mem_access_unit #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_wb_ctlin,
    input  logic        i_memread,
    input  logic        i_memwrite,
    input  logic        i_branch,
    input  logic        i_zero,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rdata2,
    input  logic [4:0]  i_dest_reg,
    output logic        o_pcsrc,
    output logic        o_stall,
    output logic [1:0]  o_wb_ctlout,
    output logic [31:0] o_read_data,
    output logic [31:0] o_alu_passthru,
    output logic [4:0]  o_dest_out,
    output logic        o_mem_valid,
    output logic        o_misalign
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic [2:0] LP_WS   = 3'(WAIT_STATES);

    logic [0:0]  r_state;
    logic [2:0]  r_cnt;
    logic [1:0]  r_wb_ctlout;
    logic [31:0] r_read_data;
    logic [31:0] r_alu_passthru;
    logic [4:0]  r_dest_out;
    logic        r_mem_valid;
    logic        r_misalign;

    // Request captured on acceptance so input changes during WAIT are ignored.
    logic [1:0]  r_req_wb;
    logic        r_req_wr;
    logic [31:0] r_req_alu;
    logic [31:0] r_req_wdata;
    logic [4:0]  r_req_dest;

    // NOTE: RAM has no reset; contents survive rst and need no reset fan-out.
    logic [31:0] r_mem [2**ADDR_BITS];

    logic                 w_req;
    logic                 w_aligned;
    logic                 w_complete;
    logic                 w_mem_we;
    logic [1:0]           w_sel_wb;
    logic                 w_sel_wr;
    logic [31:0]          w_sel_alu;
    logic [31:0]          w_sel_wdata;
    logic [4:0]           w_sel_dest;
    logic [ADDR_BITS-1:0] w_sel_idx;

    assign w_req     = i_memread | i_memwrite;
    assign w_aligned = (i_alu_result[1:0] == 2'b00);

    assign w_sel_wb    = (r_state == ST_WAIT) ? r_req_wb    : i_wb_ctlin;
    assign w_sel_wr    = (r_state == ST_WAIT) ? r_req_wr    : i_memwrite;
    assign w_sel_alu   = (r_state == ST_WAIT) ? r_req_alu   : i_alu_result;
    assign w_sel_wdata = (r_state == ST_WAIT) ? r_req_wdata : i_rdata2;
    assign w_sel_dest  = (r_state == ST_WAIT) ? r_req_dest  : i_dest_reg;
    assign w_sel_idx   = w_sel_alu[ADDR_BITS+1:2];

    assign w_complete = ((r_state == ST_IDLE) && w_req && w_aligned && (WAIT_STATES == 0))
                     || ((r_state == ST_WAIT) && (r_cnt == 3'd1));
    assign w_mem_we   = w_complete && w_sel_wr && !rst;

    assign o_stall = ((r_state == ST_IDLE) && w_req && w_aligned && (WAIT_STATES != 0))
                  || ((r_state == ST_WAIT) && (r_cnt > 3'd1));
    assign o_pcsrc = i_branch & i_zero;

    // NOTE: all state updates use non-blocking assignment so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 3'd0;
            r_wb_ctlout    <= 2'b00;
            r_read_data    <= 32'd0;
            r_alu_passthru <= 32'd0;
            r_dest_out     <= 5'd0;
            r_mem_valid    <= 1'b0;
            r_misalign     <= 1'b0;
            r_req_wb       <= 2'b00;
            r_req_wr       <= 1'b0;
            r_req_alu      <= 32'd0;
            r_req_wdata    <= 32'd0;
            r_req_dest     <= 5'd0;
        end else begin
            r_misalign <= 1'b0;
            if (w_complete) begin
                r_state        <= ST_IDLE;
                r_cnt          <= 3'd0;
                r_wb_ctlout    <= w_sel_wb;
                r_read_data    <= r_mem[w_sel_idx];
                r_alu_passthru <= w_sel_alu;
                r_dest_out     <= w_sel_dest;
                r_mem_valid    <= 1'b1;
            end else if (r_state == ST_WAIT) begin
                r_cnt       <= r_cnt - 3'd1;
                r_wb_ctlout <= 2'b00;
                r_mem_valid <= 1'b0;
            end else if (!w_req) begin
                r_wb_ctlout    <= i_wb_ctlin;
                r_read_data    <= 32'd0;
                r_alu_passthru <= i_alu_result;
                r_dest_out     <= i_dest_reg;
                r_mem_valid    <= 1'b1;
            end else if (!w_aligned) begin
                // Misaligned access is dropped: retire as a no-writeback slot.
                r_wb_ctlout    <= 2'b00;
                r_read_data    <= 32'd0;
                r_alu_passthru <= i_alu_result;
                r_dest_out     <= i_dest_reg;
                r_mem_valid    <= 1'b1;
                r_misalign     <= 1'b1;
            end else begin
                r_state     <= ST_WAIT;
                r_cnt       <= LP_WS;
                r_wb_ctlout <= 2'b00;
                r_mem_valid <= 1'b0;
                r_req_wb    <= i_wb_ctlin;
                r_req_wr    <= i_memwrite;
                r_req_alu   <= i_alu_result;
                r_req_wdata <= i_rdata2;
                r_req_dest  <= i_dest_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_sel_idx] <= w_sel_wdata;
        end
    end

    assign o_wb_ctlout    = r_wb_ctlout;
    assign o_read_data    = r_read_data;
    assign o_alu_passthru = r_alu_passthru;
    assign o_dest_out     = r_dest_out;
    assign o_mem_valid    = r_mem_valid;
    assign o_misalign     = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (ADDR_BITS=8, WAIT_STATES=2).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_ctlin;
    logic        memread, memwrite, branch, zero;
    logic [31:0] alu_result, rdata2;
    logic [4:0]  dest_reg;
    logic        pcsrc, stall, mem_valid, misalign;
    logic [1:0]  wb_ctlout;
    logic [31:0] read_data, alu_passthru;
    logic [4:0]  dest_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_BITS(8), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst),
        .i_wb_ctlin(wb_ctlin), .i_memread(memread), .i_memwrite(memwrite),
        .i_branch(branch), .i_zero(zero), .i_alu_result(alu_result),
        .i_rdata2(rdata2), .i_dest_reg(dest_reg),
        .o_pcsrc(pcsrc), .o_stall(stall), .o_wb_ctlout(wb_ctlout),
        .o_read_data(read_data), .o_alu_passthru(alu_passthru),
        .o_dest_out(dest_out), .o_mem_valid(mem_valid), .o_misalign(misalign)
    );

    typedef struct {
        logic [1:0]  wb;
        logic        rd, wr, br, zr;
        logic [31:0] alu, wd;
        logic [4:0]  dest;
        logic        e_stall, e_pcsrc;
        logic [1:0]  e_wb;
        logic        e_valid, e_mis;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] dest, input logic [1:0] wb);
        memread = rd; memwrite = wr; alu_result = addr; rdata2 = wd;
        dest_reg = dest; wb_ctlin = wb; branch = 1'b0; zero = 1'b0;
    endtask

    // One aligned access: stall must be 1,1,0 and results land on the third edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] dest, input logic [1:0] wb,
                          input logic chk_rd, input logic [31:0] exp_rd,
                          input logic chg, input string nm);
        int stalls = 0;
        @(negedge clk);
        drive(rd, wr, addr, wd, dest, wb);
        for (int c = 0; c < 3; c++) begin
            #1;
            if (stall) stalls++;
            @(posedge clk);
            #1;
            if (c < 2) begin
                check({nm, " bubble valid"}, 32'(mem_valid), 32'd0);
                check({nm, " bubble wb"}, 32'(wb_ctlout), 32'd0);
                @(negedge clk);
                if (chg) begin
                    alu_result = 32'h0000_0020;
                    dest_reg   = 5'd1;
                end
            end
        end
        check({nm, " stall cycles"}, 32'(stalls), 32'd2);
        check({nm, " valid"}, 32'(mem_valid), 32'd1);
        check({nm, " wb"}, 32'(wb_ctlout), 32'(wb));
        check({nm, " dest"}, 32'(dest_out), 32'(dest));
        check({nm, " alu"}, alu_passthru, addr);
        if (chk_rd) check({nm, " read_data"}, read_data, exp_rd);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        wb     rd    wr    br    zr    alu            wd             dest  stl   pcs   e_wb   val   mis
        vecs[0] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0,         5'd7, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[1] = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_5678, 32'h0,         5'd3, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[2] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_9ABC, 32'h0,         5'd3, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[3] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         5'd9, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};
        vecs[4] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         5'd2, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[5] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0022, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};
        vecs[6] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
        #2;
        check("reset wb", 32'(wb_ctlout), 32'd0);
        check("reset read_data", read_data, 32'd0);
        check("reset alu", alu_passthru, 32'd0);
        check("reset dest", 32'(dest_out), 32'd0);
        check("reset valid", 32'(mem_valid), 32'd0);
        check("reset misalign", 32'(misalign), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0, 2'b00, 1'b0, 32'd0, 1'b0, "sw 0x10");
        access(1'b1, 1'b0, 32'h10, 32'd0, 5'd4, 2'b11, 1'b1, 32'hDEAD_BEEF, 1'b0, "lw 0x10");
        access(1'b1, 1'b1, 32'h10, 32'h1111_1111, 5'd5, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0, "ld+st 0x10");
        access(1'b1, 1'b0, 32'h10, 32'd0, 5'd6, 2'b11, 1'b1, 32'h1111_1111, 1'b0, "lw after ld+st");
        access(1'b0, 1'b1, 32'h20, 32'hAAAA_AAAA, 5'd0, 2'b00, 1'b0, 32'd0, 1'b0, "sw 0x20");

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            wb_ctlin = vecs[i].wb; memread = vecs[i].rd; memwrite = vecs[i].wr;
            branch = vecs[i].br; zero = vecs[i].zr; alu_result = vecs[i].alu;
            rdata2 = vecs[i].wd; dest_reg = vecs[i].dest;
            #1;
            check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d pcsrc", i), 32'(pcsrc), 32'(vecs[i].e_pcsrc));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d wb", i), 32'(wb_ctlout), 32'(vecs[i].e_wb));
            check($sformatf("vec%0d alu", i), alu_passthru, vecs[i].alu);
            check($sformatf("vec%0d dest", i), 32'(dest_out), 32'(vecs[i].dest));
            check($sformatf("vec%0d valid", i), 32'(mem_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d misalign", i), 32'(misalign), 32'(vecs[i].e_mis));
            if (!vecs[i].e_mis) check($sformatf("vec%0d read_data", i), read_data, 32'd0);
        end

        access(1'b1, 1'b0, 32'h20, 32'd0, 5'd8, 2'b11, 1'b1, 32'hAAAA_AAAA, 1'b0, "lw 0x20 after misaligned sw");

        // Reset pulse while a store sits in WAIT.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h20, 32'h0000_0055, 5'd0, 2'b00);
        @(posedge clk);
        #1;
        check("abort in WAIT stall", 32'(stall), 32'd1);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
        #1;
        check("abort wb", 32'(wb_ctlout), 32'd0);
        check("abort read_data", read_data, 32'd0);
        check("abort alu", alu_passthru, 32'd0);
        check("abort dest", 32'(dest_out), 32'd0);
        check("abort valid", 32'(mem_valid), 32'd0);
        check("abort stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        access(1'b1, 1'b0, 32'h20, 32'd0, 5'd10, 2'b11, 1'b1, 32'hAAAA_AAAA, 1'b0, "lw 0x20 after abort");

        access(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 5'd0, 2'b00, 1'b0, 32'd0, 1'b0, "sw 0x400");
        access(1'b1, 1'b0, 32'h000, 32'd0, 5'd11, 2'b11, 1'b1, 32'hCAFE_F00D, 1'b0, "lw 0x000 wrap");

        access(1'b1, 1'b0, 32'h10, 32'd0, 5'd12, 2'b11, 1'b1, 32'h1111_1111, 1'b1, "lw inputs change in WAIT");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
